// File: rtl/smg_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller:
// digit count, FSM states, digit record layout and segment pattern table.
package smg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
   localparam logic [7:0]  CS_NONE    = 8'hFF;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   typedef struct packed {
      logic       on;
      logic       dp;
      logic [3:0] hex;
   } digit_t;

   // Segment patterns {g,f,e,d,c,b,a}, indexed by hex value (entry 0 is rightmost).
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/smg_hex_decode.sv
// Combinational hex-to-segment decode; a blanked digit drives no segments.
module smg_hex_decode
   import smg_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       dp,
   input  logic       on,
   output logic [7:0] seg
);

   always_comb begin
      seg = on ? {dp, SEG_TABLE[hex]} : 8'h00;
   end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed scan controller for an 8-digit common-cathode display:
// cycles OFF -> BLANK -> SHOW per digit, with registered segment/select outputs.
module smg_scan_ctrl
   import smg_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       disp_en,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [5:0] wr_data,
   output logic [7:0] SMG,
   output logic [7:0] SMG_CS,
   output logic       frame_done
);

   localparam int unsigned      CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             frame_nxt;
   logic [7:0]       cs_nxt;
   logic [7:0]       seg_dec;
   digit_t           regs [NUM_DIGITS];
   digit_t           cur;

   // NOTE: the register file is small and must read back blank after reset,
   // so every entry is reset explicitly rather than left as plain RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_addr] <= digit_t'(wr_data);
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      frame_nxt = 1'b0;
      if (!disp_en) begin
         state_nxt = ST_OFF;
         cnt_nxt   = '0;
         idx_nxt   = '0;
      end else begin
         unique case (state)
            ST_OFF: begin
               state_nxt = ST_BLANK;
               cnt_nxt   = '0;
            end
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nxt = ST_SHOW;
                  cnt_nxt   = '0;
               end
            end
            ST_SHOW: begin
               if (cnt == SHOW_LAST) begin
                  state_nxt = ST_BLANK;
                  cnt_nxt   = '0;
                  idx_nxt   = idx + 1'b1;
                  frame_nxt = (idx == IDX_W'(NUM_DIGITS - 1));
               end
            end
            default: begin
               state_nxt = ST_OFF;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state so the registered drive lines
   // change on the same edge as the FSM, not one cycle behind it.
   assign cur    = regs[idx_nxt];
   assign cs_nxt = (state_nxt == ST_SHOW) ? ~(8'(1) << idx_nxt) : CS_NONE;

   smg_hex_decode u_dec (
      .hex (cur.hex),
      .dp  (cur.dp),
      .on  (cur.on),
      .seg (seg_dec)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         cnt        <= '0;
         idx        <= '0;
         SMG        <= 8'h00;
         SMG_CS     <= CS_NONE;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         SMG        <= (state_nxt == ST_SHOW) ? seg_dec : 8'h00;
         SMG_CS     <= cs_nxt;
         frame_done <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Self-checking bench for smg_scan_ctrl: decode table, directed scan sequences,
// and randomized traffic against a time-slot model of the display scan.
module tb_smg_scan_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 2;
   localparam int SLOT      = CLK_DIV + BLANK_CYC;
   localparam int FRAME     = 8 * SLOT;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       disp_en;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [5:0] wr_data;
   logic [7:0] SMG;
   logic [7:0] SMG_CS;
   logic       frame_done;

   smg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .disp_en    (disp_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .SMG        (SMG),
      .SMG_CS     (SMG_CS),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int fd_seen = 0;

   // Reference model: time since enable, split into fixed per-digit slots.
   bit         running = 1'b0;
   int         k = 0;
   logic [5:0] mem [8];

   localparam logic [6:0] SEGS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [7:0] exp_seg(input logic [5:0] d);
      return d[5] ? {d[4], SEGS[d[3:0]]} : 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic en, input logic we, input logic [2:0] a, input logic [5:0] d);
      logic [7:0] e_cs, e_smg;
      logic       e_fd;
      int         slot;
      disp_en = en; wr_en = we; wr_addr = a; wr_data = d;
      @(posedge clk);
      if (!en) begin
         running = 1'b0; k = 0;
      end else if (!running) begin
         running = 1'b1; k = 0;
      end else begin
         k++;
      end
      e_cs = 8'hFF; e_smg = 8'h00; e_fd = 1'b0;
      if (running) begin
         slot = (k / SLOT) % 8;
         if ((k % SLOT) >= BLANK_CYC) begin
            e_cs  = ~(8'd1 << slot);
            e_smg = exp_seg(mem[slot]);
         end
         e_fd = (k > 0) && (k % FRAME == 0);
      end
      if (we) mem[a] = d;
      #1;
      check("cs", SMG_CS, e_cs);
      check("smg", SMG, e_smg);
      check("frame_done", frame_done, e_fd);
      if (frame_done) fd_seen++;
   endtask

   task automatic run_until(input int target);
      int n = 0;
      while (!(running && k == target) && n < 300) begin
         tick(1'b1, 1'b0, 3'd0, 6'd0);
         n++;
      end
      if (n >= 300) begin
         total++; bad++;
         $display("FAIL run_until: timed out waiting for slot time %0d", target);
      end
   endtask

   typedef struct {
      logic [5:0] data;
      logic [7:0] exp_smg;
   } dec_vec_t;

   dec_vec_t vecs [20];

   initial begin
      int fd_before;
      vecs = '{
         '{6'h20, 8'h3F}, '{6'h21, 8'h06}, '{6'h22, 8'h5B}, '{6'h23, 8'h4F},
         '{6'h24, 8'h66}, '{6'h25, 8'h6D}, '{6'h26, 8'h7D}, '{6'h27, 8'h07},
         '{6'h28, 8'h7F}, '{6'h29, 8'h6F}, '{6'h2A, 8'h77}, '{6'h2B, 8'h7C},
         '{6'h2C, 8'h39}, '{6'h2D, 8'h5E}, '{6'h2E, 8'h79}, '{6'h2F, 8'h71},
         '{6'h38, 8'hFF}, '{6'h18, 8'h00}, '{6'h30, 8'hBF}, '{6'h0F, 8'h00}
      };
      for (int i = 0; i < 8; i++) mem[i] = 6'h00;
      rst_n = 1'b0; disp_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      #12;
      check("reset_cs", SMG_CS, 8'hFF);
      check("reset_smg", SMG, 8'h00);
      check("reset_fd", frame_done, 1'b0);
      rst_n = 1'b1;

      // Display held dark.
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 3'd0, 6'd0);
      check("dark_no_fd", fd_seen, 0);

      // Decode table, shown on digit 0.
      foreach (vecs[i]) begin
         tick(1'b0, 1'b1, 3'd0, vecs[i].data);
         run_until(BLANK_CYC);
         check("dec_smg", SMG, vecs[i].exp_smg);
         check("dec_cs", SMG_CS, 8'hFE);
         tick(1'b0, 1'b0, 3'd0, 6'd0);
      end

      // Full scan of digits 0..7 with two frames and a wrap.
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 3'(i), {2'b10, 4'(i)});
      fd_before = fd_seen;
      run_until(2 * FRAME);
      check("two_frames", fd_seen - fd_before, 2);
      run_until(2 * FRAME + BLANK_CYC);
      check("wrap_cs", SMG_CS, 8'hFE);
      check("wrap_smg", SMG, 8'h3F);

      // Live write to the digit being shown.
      tick(1'b0, 1'b0, 3'd0, 6'd0);
      run_until(3 * SLOT + BLANK_CYC);
      tick(1'b1, 1'b1, 3'd3, 6'h3A);
      check("live_cs_before", SMG_CS, 8'hF7);
      tick(1'b1, 1'b0, 3'd0, 6'd0);
      check("live_smg", SMG, 8'hF7);
      check("live_cs", SMG_CS, 8'hF7);
      tick(1'b1, 1'b0, 3'd0, 6'd0);
      check("live_cs_end", SMG_CS, 8'hF7);

      // Blanked digit 5.
      tick(1'b1, 1'b1, 3'd5, 6'h15);
      run_until(5 * SLOT + BLANK_CYC + 1);
      check("off_digit_cs", SMG_CS, 8'hDF);
      check("off_digit_smg", SMG, 8'h00);

      // Enable dropped during digit 6, then restored.
      run_until(6 * SLOT + BLANK_CYC + 1);
      fd_before = fd_seen;
      tick(1'b0, 1'b0, 3'd0, 6'd0);
      check("drop_cs", SMG_CS, 8'hFF);
      tick(1'b1, 1'b0, 3'd0, 6'd0);
      tick(1'b1, 1'b0, 3'd0, 6'd0);
      check("reen_blank", SMG_CS, 8'hFF);
      tick(1'b1, 1'b0, 3'd0, 6'd0);
      check("reen_cs", SMG_CS, 8'hFE);
      check("drop_no_fd", fd_seen - fd_before, 0);

      // Randomized writes and enable drops.
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 99) < 97, $urandom_range(0, 3) == 0,
              3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      end

      // Asynchronous reset during a SHOW phase.
      run_until(2 * SLOT + BLANK_CYC);
      #1 rst_n = 1'b0;
      #1;
      check("async_cs", SMG_CS, 8'hFF);
      check("async_smg", SMG, 8'h00);
      check("async_fd", frame_done, 1'b0);
      running = 1'b0; k = 0;
      for (int i = 0; i < 8; i++) mem[i] = 6'h00;
      #1 rst_n = 1'b1;
      run_until(BLANK_CYC);
      check("rst_mem_cs", SMG_CS, 8'hFE);
      check("rst_mem_smg", SMG, 8'h00);
      run_until(FRAME + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/smg_scan_ctrl.md
SMG_SCAN_CTRL -- requirements
Module: smg_scan_ctrl

Interface
REQ-001 Parameter: CLK_DIV, 50000, clk cycles each digit is shown (SHOW dwell); legal range 2..2^20.
REQ-002 Parameter: BLANK_CYC, 16, clk cycles all digits are off between digits (anti-ghosting); legal range 1..2^8, less than CLK_DIV.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 disp_en  input  1  1 = scan running, 0 = display dark.
REQ-006 wr_en  input  1  single-cycle write strobe for the digit register file.
REQ-007 wr_addr  input  3  digit index written (0 = rightmost, CS bit 0).
REQ-008 wr_data  input  6  {on, dp, hex[3:0]}; on=0 blanks that digit.
REQ-009 SMG  output  8  segment drive, active-high, bit order {dp,g,f,e,d,c,b,a}.
REQ-010 SMG_CS  output  8  digit select, active-low one-hot; all-ones = no digit.
REQ-011 frame_done  output  1  one-cycle pulse at end of digit 7 SHOW.

Function
REQ-012 The block SHALL hold an 8-entry x 6-bit digit register file; a wr_en write SHALL take effect at the next rising edge, with the last write winning.
REQ-013 The FSM SHALL have states OFF, BLANK, SHOW.
REQ-014 OFF: SMG_CS=8'hFF, SMG=8'h00, digit index held at 0; exit to BLANK when disp_en=1.
REQ-015 BLANK: SMG_CS=8'hFF, SMG=8'h00 for exactly BLANK_CYC cycles, then go to SHOW.
REQ-016 SHOW: SMG_CS bit[idx]=0, all other bits 1, for exactly CLK_DIV cycles; then idx increments modulo 8 (7 wraps to 0) and the FSM goes to BLANK.
REQ-017 frame_done SHALL pulse high for one cycle on the SHOW->BLANK transition when idx=7.
REQ-018 disp_en falling in any state SHALL force OFF on the next edge, reset the dwell counter and idx, and produce no frame_done.
REQ-019 In SHOW, SMG SHALL be decode(hex) with bit7=dp when on=1, and 8'h00 when on=0.
REQ-020 The hex decode SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71 (hex, bits g..a).
REQ-021 A write to the currently shown digit SHALL appear on SMG one cycle after the write edge; SMG_CS SHALL be unaffected.
REQ-022 SMG, SMG_CS and frame_done SHALL be registered outputs, with no combinational path from any input.
REQ-023 The first SHOW after leaving OFF SHALL be digit 0.

Reset
REQ-024 While rst_n=0: state=OFF, idx=0, dwell counter=0, all register entries=6'b000000, SMG=8'h00, SMG_CS=8'hFF, frame_done=0.
REQ-025 Reset asserted mid-SHOW SHALL blank outputs immediately (asynchronously), without waiting for a clock edge.
REQ-026 After rst_n deasserts, the block SHALL behave per REQ-014 on the first edge.

Structure
REQ-027 Shared package smg_pkg SHALL hold: NUM_DIGITS=8, the FSM state enum, the 16-entry segment pattern table, and CS_NONE=8'hFF.
REQ-028 The hex-to-segment decode SHALL be a combinational sub-module smg_hex_decode (input hex[3:0], dp, on; output seg[7:0]).
REQ-029 The dwell counter SHALL be one shared counter, sized for CLK_DIV, reused for the BLANK and SHOW phases.

Verification (CLK_DIV=4, BLANK_CYC=2)
REQ-030 Reset, then hold disp_en=0 for 20 cycles -> SMG_CS=FF, SMG=00, frame_done never high.
REQ-031 Write digit i = {1,0,i} for i=0..7, then raise disp_en -> CS sequence FE,FD,...,7F, each held 4 cycles with 2 cycles of FF between; SMG shows 3F,06,...,07; one frame_done per 48 cycles; wraps to FE.
REQ-032 Write digit 3 = {1,1,A} during digit 3 SHOW -> SMG changes to F7 on the next cycle; CS stays F7 for the full 4 cycles.
REQ-033 Write digit 5 with on=0 -> during CS=DF, SMG=00.
REQ-034 Drop disp_en during digit 6 SHOW -> next cycle CS=FF; re-enable -> first CS=FE after 2 blank cycles; no frame_done.
REQ-035 Assert rst_n=0 mid-SHOW between clock edges -> SMG=00 and CS=FF before the next edge; all digit entries read back as blank after restart.
